// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: rotating priority among NUM_REQ pixel producers,
// bounded bursts, valid/ready per requester, registered write stage.
module fb_write_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned BURST_MAX = 64,
    localparam int unsigned IdW      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]     req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      grant_valid,
    output logic [IdW-1:0]            grant_id,
    output logic                      fb_we,
    output logic [ADDR_W-1:0]         fb_addr,
    output logic [31:0]               fb_wdata
);

    localparam logic [15:0] BurstLast = 16'(BURST_MAX - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_t;

    state_t              state_q, state_d;
    logic [IdW-1:0]      gid_q, gid_d;
    logic [IdW-1:0]      rr_q, rr_d;
    logic [15:0]         beat_q, beat_d;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [31:0]         fb_wdata_q, fb_wdata_d;

    logic                own_valid, own_last, accept, release_grant;
    logic [ADDR_W-1:0]   own_addr;
    logic [31:0]         own_data;
    logic [IdW-1:0]      hi_id, lo_id, win_id, nxt_ptr;
    logic                hi_found;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            gid_q      <= '0;
            rr_q       <= '0;
            beat_q     <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gid_q      <= gid_d;
            rr_q       <= rr_d;
            beat_q     <= beat_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
        end
    end

    // Owner selection and rotating-priority winner search (lowest index wins each pass).
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_addr  = '0;
        own_data  = '0;
        hi_id     = '0;
        lo_id     = '0;
        hi_found  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (gid_q == IdW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_addr  = req_addr[i*ADDR_W +: ADDR_W];
                own_data  = req_data[i*32 +: 32];
            end
            if (req_valid[i]) begin
                lo_id = IdW'(i);
                if (IdW'(i) >= rr_q) begin
                    hi_id    = IdW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        win_id        = hi_found ? hi_id : lo_id;
        nxt_ptr       = (32'(gid_q) + 32'd1 >= NUM_REQ) ? '0 : gid_q + IdW'(1);
        accept        = (state_q == StGrant) && own_valid;
        release_grant = (state_q == StGrant) &&
                        (!own_valid || own_last || (beat_q == BurstLast));
    end

    always_comb begin
        state_d    = state_q;
        gid_d      = gid_q;
        rr_d       = rr_q;
        beat_d     = beat_q;
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    state_d = StGrant;
                    gid_d   = win_id;
                    beat_d  = '0;
                end
            end
            StGrant: begin
                if (accept) begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = own_addr;
                    fb_wdata_d = own_data;
                    beat_d     = beat_q + 16'd1;
                end
                if (release_grant) begin
                    state_d = StIdle;
                    rr_d    = nxt_ptr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state_q == StGrant) && (gid_q == IdW'(i)) && req_valid[i];
        end
        grant_valid = (state_q == StGrant);
        grant_id    = gid_q;
        fb_we       = fb_we_q;
        fb_addr     = fb_addr_q;
        fb_wdata    = fb_wdata_q;
    end

endmodule
